// File: rtl/hall_sensor_emulator.sv
`default_nettype none
// ============================================================================
// Module   : hall_sensor_emulator
// Purpose  : Emulates the 3-bit Hall sensor sequence of a turning BLDC rotor
//            at a programmable electrical step rate and direction. It acts as
//            the source end of the hall_signal link into the commutation
//            decoder. A fault input forces the invalid code 3'b000.
// Ports    : clk            - system clock, rising edge
//            rst            - synchronous active-high reset
//            enable         - 1 = rotor turning, 0 = rotor frozen
//            direction      - 0 = forward sequence, 1 = reverse sequence
//            step_period    - clk cycles per Hall step, 0 = stopped
//            inject_fault   - 1 = hall_signal forced to 3'b000
//            hall_signal    - emulated Hall code (registered)
//            sector         - electrical sector 0..5 (registered)
//            step_pulse     - one-cycle pulse on each sector change
//            elec_rev_pulse - one-cycle pulse on each electrical revolution
//            rev_count      - electrical revolution counter, wraps
// Revision : 1.0 - initial release
// ============================================================================
module hall_sensor_emulator #(
    parameter int CNT_WIDTH = 16,
    parameter int REV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 direction,
    input  logic [CNT_WIDTH-1:0] step_period,
    input  logic                 inject_fault,
    output logic [2:0]           hall_signal,
    output logic [2:0]           sector,
    output logic                 step_pulse,
    output logic                 elec_rev_pulse,
    output logic [REV_WIDTH-1:0] rev_count
);

    localparam logic [2:0] c_SECTOR_LAST = 3'd5;
    localparam logic [2:0] c_HALL_FAULT  = 3'b000;
    localparam logic [2:0] c_HALL_RESET  = 3'b001;

    logic [CNT_WIDTH-1:0] counter_q,   counter_d;
    logic [2:0]           sector_q,    sector_d;
    logic [2:0]           hall_q,      hall_d;
    logic                 step_q,      step_d;
    logic                 rev_q,       rev_d;
    logic [REV_WIDTH-1:0] rev_count_q, rev_count_d;

    logic w_running;
    logic w_step_due;
    logic w_sector_valid;

    function automatic logic [2:0] hall_code(input logic [2:0] s);
        logic [2:0] code;
        case (s)
            3'd0:    code = 3'b001;
            3'd1:    code = 3'b011;
            3'd2:    code = 3'b010;
            3'd3:    code = 3'b110;
            3'd4:    code = 3'b100;
            3'd5:    code = 3'b101;
            default: code = 3'b001;
        endcase
        return code;
    endfunction

    // A zero period means stopped, so the subtraction below never underflows
    // when it matters. Using >= lets a shortened period take effect at once.
    assign w_running      = enable && (step_period != '0);
    assign w_step_due     = (counter_q >= (step_period - CNT_WIDTH'(1)));
    assign w_sector_valid = (sector_q <= c_SECTOR_LAST);

    always_comb begin
        counter_d   = counter_q;
        sector_d    = sector_q;
        step_d      = 1'b0;
        rev_d       = 1'b0;
        rev_count_d = rev_count_q;

        if (!w_running) begin
            counter_d = '0;
        end else if (w_step_due) begin
            counter_d = '0;
            if (w_sector_valid) begin
                step_d = 1'b1;
                if (!direction) begin
                    if (sector_q == c_SECTOR_LAST) begin
                        sector_d = 3'd0;
                        rev_d    = 1'b1;
                    end else begin
                        sector_d = sector_q + 3'd1;
                    end
                end else begin
                    if (sector_q == 3'd0) begin
                        sector_d = c_SECTOR_LAST;
                        rev_d    = 1'b1;
                    end else begin
                        sector_d = sector_q - 3'd1;
                    end
                end
            end
        end else begin
            counter_d = counter_q + CNT_WIDTH'(1);
        end

        // Sectors 6/7 cannot be reached normally; recover to sector 0.
        if (!w_sector_valid) begin
            sector_d = 3'd0;
        end

        if (rev_d) begin
            rev_count_d = rev_count_q + REV_WIDTH'(1);
        end

        // Code follows the next sector so hall_signal and sector move together.
        hall_d = inject_fault ? c_HALL_FAULT : hall_code(sector_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter_q   <= '0;
            sector_q    <= 3'd0;
            hall_q      <= c_HALL_RESET;
            step_q      <= 1'b0;
            rev_q       <= 1'b0;
            rev_count_q <= '0;
        end else begin
            counter_q   <= counter_d;
            sector_q    <= sector_d;
            hall_q      <= hall_d;
            step_q      <= step_d;
            rev_q       <= rev_d;
            rev_count_q <= rev_count_d;
        end
    end

    assign hall_signal    = hall_q;
    assign sector         = sector_q;
    assign step_pulse     = step_q;
    assign elec_rev_pulse = rev_q;
    assign rev_count      = rev_count_q;

endmodule
`default_nettype wire

// File: doc/hall_sensor_emulator.md
Name: hall_sensor_emulator

Overview:
Generates the 3-bit Hall sensor sequence of a rotating BLDC motor at a programmable electrical step rate and direction. It is the source end of the hall_signal interface that our commutation decoder consumes. It provides closed-loop bench and FPGA bring-up without a physical motor. A fault-injection input forces invalid Hall codes so the decoder's "no phase" path can be exercised.

Parameters:
CNT_WIDTH, 16, width of step_period and the internal step-timing counter
REV_WIDTH, 16, width of rev_count

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
enable  input  1  1 = rotor turning, 0 = rotor frozen
direction  input  1  0 = forward sequence, 1 = reverse sequence
step_period  input  CNT_WIDTH  clk cycles per Hall step; 0 = stopped
inject_fault  input  1  1 = drive invalid code 3'b000 on hall_signal
hall_signal  output  3  emulated Hall sensor code
sector  output  3  current electrical sector, 0..5
step_pulse  output  1  one-cycle pulse on every sector change
elec_rev_pulse  output  1  one-cycle pulse on each electrical-revolution wrap
rev_count  output  REV_WIDTH  count of electrical revolutions, wraps modulo 2^REV_WIDTH

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. rst is sampled on the rising edge of clk and overrides all other inputs.
- Reset values:
  - sector = 0, hall_signal = 3'b001.
  - step_pulse = 0, elec_rev_pulse = 0, rev_count = 0.
  - Internal counter = 0.
- Sector to Hall code mapping: 0→001, 1→011, 2→010, 3→110, 4→100, 5→101.
  - Sector 6 and 7 are unreachable. If reached anyway, the next edge forces sector = 0.
- Registered outputs: all outputs are registered. hall_signal, sector, step_pulse and elec_rev_pulse update on the same edge. There is no combinational path from inputs to outputs.
- Step timing (enable = 1 and step_period ≥ 1):
  - The counter increments every cycle.
  - When counter ≥ step_period − 1: counter ← 0, sector advances one step, step_pulse = 1 for that cycle.
  - In steady state, hall_signal changes exactly every step_period cycles.
  - step_period = 1 gives a change on every cycle.
- Sector advance:
  - direction = 0: sector ← (sector + 1) mod 6.
  - direction = 1: sector ← (sector + 5) mod 6.
- Period change mid-step: takes effect immediately through the ≥ compare. If the new value − 1 is ≤ the current count, the step occurs on the next edge. No overflow and no missed steps.
- Direction change mid-step: the counter is not reset. The new direction applies at the next step.
- Revolution tracking:
  - elec_rev_pulse = 1 on a forward 5→0 transition or a reverse 0→5 transition.
  - rev_count increments on each elec_rev_pulse, regardless of direction, and wraps to 0.
- Stopped states:
  - enable = 0: counter cleared to 0. sector, hall_signal and rev_count hold. Pulses stay 0.
  - step_period = 0 with enable = 1: same as enable = 0.
  - On re-enable, the first step occurs step_period cycles later.
- Fault injection:
  - inject_fault = 1: the hall_signal register loads 3'b000. sector, counter, pulses and rev_count keep operating normally.
  - inject_fault = 0: on the next edge, hall_signal loads the mapped code of the current sector.
- Reset mid-operation: on the next edge all state returns to reset values, regardless of enable, the counter value or inject_fault.

Test Plan:
1. Reset release, enable = 1, direction = 0, step_period = 4:
   - hall_signal = 001, then 011, 010, 110, 100, 101, 001, each held 4 cycles.
   - step_pulse fires every 4 cycles.
   - elec_rev_pulse fires on the 5→0 step; rev_count = 1 after 24 cycles.
2. direction = 1, step_period = 2, starting at sector 0:
   - hall_signal = 001, 101, 100, 110, 010, 011, 001 every 2 cycles.
   - elec_rev_pulse fires on the 0→5 step.
3. step_period = 100, counter at 50, step_period changed to 10:
   - Step occurs on the next edge; subsequent steps every 10 cycles.
   - Then set step_period = 0: hall_signal frozen, step_pulse = 0, counter reads 0.
4. enable = 0 for 20 cycles mid-step at sector 3:
   - hall_signal stays 110, no pulses.
   - Re-enable with step_period = 5: first change to 100 exactly 5 cycles later.
5. inject_fault = 1 for 12 cycles, step_period = 3:
   - hall_signal = 000 throughout; sector advances 4 steps.
   - After release, hall_signal = mapped code of the current sector on the next edge.
   - Feeding commutation yields 3'b000 during the fault.
6. rst asserted at sector 4 with counter mid-count:
   - Next edge: hall_signal = 001, sector = 0, rev_count = 0, pulses 0.
   - Rotation restarts from sector 0 after rst deasserts.
